// File: rtl/jt900h_simirq_pkg.sv
// jt900h_simirq_pkg: shared register layout and channel state encoding for the
// jt900h simulation interrupt/control block.
// Optional feature macro: JT900H_SIMIRQ_RELOAD_EN (auto-reload timers).
package jt900h_simirq_pkg;

   // channel register fields
   localparam int CNT_MSB    = 15;
   localparam int CNT_LSB    = 8;
   localparam int LVL_MSB    = 2;
   localparam int LVL_LSB    = 0;
   localparam int RELOAD_BIT = 3;

   // byte distance between consecutive channel registers
   localparam int REG_STRIDE = 2;

`ifdef JT900H_SIMIRQ_RELOAD_EN
   localparam bit RELOAD_EN = 1'b1;
`else
   localparam bit RELOAD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      PEND  = 2'd2
   } chan_state_t;

   function automatic logic [15:0] chan_addr(input logic [15:0] base, input int unsigned idx);
      return base + 16'(REG_STRIDE * idx);
   endfunction

endpackage

// File: rtl/jt900h_simirq_chan.sv
// jt900h_simirq_chan: one programmable interrupt timer channel.
// Decodes its own register write, counts down on cen and holds the pending flag
// until the arbiter in the top acknowledges it.
// Optional feature macro: JT900H_SIMIRQ_RELOAD_EN (auto-reload, via package RELOAD_EN).
module jt900h_simirq_chan
   import jt900h_simirq_pkg::*;
#(
   parameter int          CNTW = 8,
   parameter logic [15:0] ADDR = 16'hFFF0
) (
   input  logic            rst_n,
   input  logic            clk,
   input  logic            cen,
   input  logic [15:0]     i_addr,
   input  logic            i_we_lo,
   input  logic [CNTW-1:0] i_cnt,
   input  logic [2:0]      i_lvl,
   input  logic            i_reload,
   input  logic            i_ack,
   output logic            o_pend,
   output logic [2:0]      o_lvl
);

   chan_state_t     r_state, w_state_nx;
   logic [CNTW-1:0] r_cnt, w_cnt_nx;
   logic [CNTW-1:0] r_n, w_n_nx;
   logic [2:0]      r_lvl, w_lvl_nx;
   logic            r_rel, w_rel_nx;
   logic            w_hit, w_run, w_expire;

   assign w_hit    = i_we_lo && (i_addr == ADDR);
   // a reloading channel keeps counting while its interrupt is pending
   assign w_run    = (r_state == COUNT) || ((r_state == PEND) && r_rel);
   // counter stepping from 1 to 0 is the expiry event
   assign w_expire = w_run && cen && (r_cnt == CNTW'(1));

   // next-state: countdown, expiry, acknowledge, register write (write has priority)
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_n_nx     = r_n;
      w_lvl_nx   = r_lvl;
      w_rel_nx   = r_rel;

      // counter sits at 0 for one cen cycle after expiry, then reloads: period N+1
      if (w_run && cen) begin
         if (r_cnt == '0) w_cnt_nx = r_n;
         else             w_cnt_nx = r_cnt - CNTW'(1);
      end

      case (r_state)
         IDLE: ;
         COUNT: begin
            if (w_expire) begin
               if (r_lvl == '0) w_state_nx = r_rel ? COUNT : IDLE;
               else             w_state_nx = PEND;
            end
         end
         PEND: begin
            // an expiry coinciding with the ack re-arms the pending flag
            if (i_ack && !w_expire) w_state_nx = r_rel ? COUNT : IDLE;
         end
         default: w_state_nx = IDLE;
      endcase

      if (w_hit) begin
         if (i_cnt == '0) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
         end else begin
            w_state_nx = COUNT;
            w_cnt_nx   = i_cnt;
            w_n_nx     = i_cnt;
            w_lvl_nx   = i_lvl;
            w_rel_nx   = RELOAD_EN & i_reload;
         end
      end
   end

   // channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_n     <= '0;
         r_lvl   <= '0;
         r_rel   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_n     <= w_n_nx;
         r_lvl   <= w_lvl_nx;
         r_rel   <= w_rel_nx;
      end
   end

   assign o_pend = (r_state == PEND);
   assign o_lvl  = r_lvl;

endmodule

// File: rtl/jt900h_simirq.sv
// jt900h_simirq: bus-snooping simulation controller with CH interrupt timers
// and a PASS/FAIL/STOP control word. Channel n register at BASE+2n, control
// word at SIMCTRL (16-bit address compare).
// Optional feature macro: JT900H_SIMIRQ_RELOAD_EN (auto-reload timers).
module jt900h_simirq
   import jt900h_simirq_pkg::*;
#(
   parameter int          CH      = 4,
   parameter int          AW      = 24,
   parameter int          CNTW    = 8,
   parameter logic [15:0] BASE    = 16'hFFF0,
   parameter logic [15:0] SIMCTRL = 16'hFFFE
) (
   input  logic          rst_n,
   input  logic          clk,
   input  logic          cen,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   din,
   input  logic [1:0]    we,
   input  logic          irq_ack,
   output logic [2:0]    intrq,
   output logic          irq,
   output logic          pass,
   output logic          fail,
   output logic          stop,
   output logic [CH-1:0] pend
);

   localparam int SELW = (CH > 1) ? $clog2(CH) : 1;

   logic [15:0]     w_a16;
   logic [CH-1:0]   w_pend, w_ack;
   logic [2:0]      w_lvl [CH];
   logic            w_found;
   logic [2:0]      w_best;
   logic [SELW-1:0] w_sel;
   logic            w_ctrl_hit;
   logic            w_unused_bits;

   logic            r_irq;
   logic [2:0]      r_intrq;
   logic [SELW-1:0] r_sel;
   logic            r_pass, r_fail, r_stop;

   assign w_a16         = addr[15:0];
   assign w_ctrl_hit    = (w_a16 == SIMCTRL);
   assign w_unused_bits = ^{addr[AW-1:16], din[7:4]};

   generate
      for (genvar g = 0; g < CH; g++) begin : g_chan
         // ack goes only to the channel the CPU currently sees on intrq
         assign w_ack[g] = irq_ack && r_irq && (r_sel == SELW'(g));

         jt900h_simirq_chan #(
            .CNTW (CNTW),
            .ADDR (chan_addr(BASE, g))
         ) u_chan (
            .rst_n    (rst_n),
            .clk      (clk),
            .cen      (cen),
            .i_addr   (w_a16),
            .i_we_lo  (we[0]),
            .i_cnt    (CNTW'(din[CNT_MSB:CNT_LSB])),
            .i_lvl    (din[LVL_MSB:LVL_LSB]),
            .i_reload (din[RELOAD_BIT]),
            .i_ack    (w_ack[g]),
            .o_pend   (w_pend[g]),
            .o_lvl    (w_lvl[g])
         );
      end
   endgenerate

   // arbiter: highest level wins, strict compare keeps the lowest index on ties
   always_comb begin
      w_found = 1'b0;
      w_best  = '0;
      w_sel   = '0;
      for (int unsigned i = 0; i < CH; i++) begin
         if (w_pend[i] && (!w_found || (w_lvl[i] > w_best))) begin
            w_found = 1'b1;
            w_best  = w_lvl[i];
            w_sel   = SELW'(i);
         end
      end
   end

   // registered interrupt presentation and control strobes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_irq   <= 1'b0;
         r_intrq <= '0;
         r_sel   <= '0;
         r_pass  <= 1'b0;
         r_fail  <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_irq   <= w_found;
         r_intrq <= w_best;
         r_sel   <= w_sel;
         r_pass  <= w_ctrl_hit && we[0] && din[0];
         r_fail  <= w_ctrl_hit && we[0] && !din[0];
         r_stop  <= w_ctrl_hit && we[1];
      end
   end

   assign irq   = r_irq;
   assign intrq = r_intrq;
   assign pass  = r_pass;
   assign fail  = r_fail;
   assign stop  = r_stop;
   assign pend  = w_pend;

endmodule

// File: tb/tb_jt900h_simirq.sv
// tb_jt900h_simirq: directed and randomized bench for jt900h_simirq with a
// behavioural model (per-channel "cen edges left until expiry") checked every cycle.
// Optional feature macro: JT900H_SIMIRQ_RELOAD_EN (auto-reload test enabled).
module tb_jt900h_simirq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic        irq_ack = 1'b0;
   logic [23:0] addr = '0;
   logic [15:0] din = '0;
   logic [1:0]  we = '0;
   logic [2:0]  intrq;
   logic        irq, pass, fail, stop;
   logic [3:0]  pend;

   int n_chk = 0;
   int n_fail = 0;

   jt900h_simirq #(
      .CH      (4),
      .AW      (24),
      .CNTW    (8),
      .BASE    (16'hFFF0),
      .SIMCTRL (16'hFFFE)
   ) dut (
      .rst_n   (rst_n),
      .clk     (clk),
      .cen     (cen),
      .addr    (addr),
      .din     (din),
      .we      (we),
      .irq_ack (irq_ack),
      .intrq   (intrq),
      .irq     (irq),
      .pass    (pass),
      .fail    (fail),
      .stop    (stop),
      .pend    (pend)
   );

   always #5 clk = ~clk;

   // behavioural model state
   bit m_act [4];
   bit m_pend[4];
   bit m_rel [4];
   int m_left[4];
   int m_n   [4];
   int m_lvl [4];
   bit m_irq, m_pass, m_fail, m_stop;
   int m_intrq, m_sel;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_act[c] = 0; m_pend[c] = 0; m_rel[c] = 0;
         m_left[c] = 0; m_n[c] = 0; m_lvl[c] = 0;
      end
      m_irq = 0; m_intrq = 0; m_sel = 0;
      m_pass = 0; m_fail = 0; m_stop = 0;
   endtask

   // one clock edge of the reference behaviour, using the inputs present at that edge
   task automatic model_step();
      bit nirq;
      int nint, nsel, cnt;
      logic [15:0] a16;
      if (!rst_n) begin
         model_reset();
         return;
      end
      // presented interrupt: scan levels from 7 down, first channel at that level
      nirq = 0; nint = 0; nsel = 0;
      for (int l = 7; l >= 1; l--)
         for (int c = 0; c < 4; c++)
            if (!nirq && m_pend[c] && m_lvl[c] == l) begin
               nirq = 1; nint = l; nsel = c;
            end
      a16 = addr[15:0];
      for (int c = 0; c < 4; c++) begin
         if (irq_ack && m_irq && m_sel == c) m_pend[c] = 0;
         if (m_act[c] && cen) begin
            m_left[c]--;
            if (m_left[c] == 0) begin
               if (m_lvl[c] != 0) m_pend[c] = 1;
               if (m_rel[c]) m_left[c] = m_n[c] + 1;
               else          m_act[c] = 0;
            end
         end
         if (we[0] && a16 == 16'hFFF0 + 16'(2 * c)) begin
            cnt = int'(din[15:8]);
            m_pend[c] = 0;
            if (cnt == 0) m_act[c] = 0;
            else begin
               m_act[c] = 1; m_left[c] = cnt; m_n[c] = cnt;
               m_lvl[c] = int'(din[2:0]);
`ifdef JT900H_SIMIRQ_RELOAD_EN
               m_rel[c] = din[3];
`else
               m_rel[c] = 0;
`endif
            end
         end
      end
      m_pass = we[0] && a16 == 16'hFFFE && din[0];
      m_fail = we[0] && a16 == 16'hFFFE && !din[0];
      m_stop = we[1] && a16 == 16'hFFFE;
      m_irq = nirq; m_intrq = nint; m_sel = nsel;
   endtask

   task automatic compare_all();
      chk("irq",   32'(irq),   32'(m_irq));
      chk("intrq", 32'(intrq), 32'(m_intrq));
      chk("pend",  32'(pend),  32'({m_pend[3], m_pend[2], m_pend[1], m_pend[0]}));
      chk("pass",  32'(pass),  32'(m_pass));
      chk("fail",  32'(fail),  32'(m_fail));
      chk("stop",  32'(stop),  32'(m_stop));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] w);
      addr = {8'($urandom), a};
      din  = d;
      we   = w;
      tick();
      we   = '0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic wait_irq(input int limit, output int k);
      k = 0;
      while (!irq && k < limit) begin
         tick();
         k++;
      end
   endtask

   logic [15:0] atbl [8];
   int k, hi_cnt, idx, cval;

   initial begin
      atbl = '{16'hFFF0, 16'hFFF2, 16'hFFF4, 16'hFFF6, 16'hFFF8, 16'hFFF1, 16'hFFFE, 16'h1234};
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_irq",   32'(irq),   32'd0);
      chk("rst_intrq", 32'(intrq), 32'd0);
      chk("rst_pend",  32'(pend),  32'd0);
      chk("rst_strb",  32'({pass, fail, stop}), 32'd0);
      rst_n = 1'b1;
      cen   = 1'b1;
      tick();

      // single timer: $0A03 -> irq at clk 11, intrq 3, ack drops irq
      wr(16'hFFF0, 16'h0A03, 2'b01);
      wait_irq(30, k);
      chk("lat_0A03", 32'(k), 32'd11);
      chk("lvl_0A03", 32'(intrq), 32'd3);
      ack();
      tick();
      chk("ack_clear", 32'(irq), 32'd0);

      // level priority: ch0 lvl2 + ch1 lvl5 expire together
      wr(16'hFFF0, 16'h0502, 2'b01);
      wr(16'hFFF2, 16'h0405, 2'b01);
      wait_irq(20, k);
      chk("prio_pend", 32'(pend), 32'h3);
      chk("prio_hi", 32'(intrq), 32'd5);
      ack(); tick();
      chk("prio_lo", 32'(intrq), 32'd2);
      ack(); tick();
      chk("prio_done", 32'(irq), 32'd0);

      // equal levels: lowest index first
      wr(16'hFFF2, 16'h0304, 2'b01);
      wr(16'hFFF4, 16'h0204, 2'b01);
      wait_irq(20, k);
      chk("tie_pend0", 32'(pend), 32'h6);
      ack();
      chk("tie_pend1", 32'(pend), 32'h4);
      tick();
      ack(); tick();
      chk("tie_done", 32'(irq), 32'd0);

      // cancel before expiry
      wr(16'hFFF2, 16'h0500, 2'b01);
      tick();
      wr(16'hFFF2, 16'h0000, 2'b01);
      hi_cnt = 0;
      repeat (20) begin tick(); hi_cnt += int'(irq); end
      chk("cancel", 32'(hi_cnt), 32'd0);

      // cen every other cycle: N=5 -> irq at clk 11 instead of 6
      wr(16'hFFF0, 16'h0501, 2'b01);
      k = 0;
      while (!irq && k < 40) begin
         k++;
         cen = (k % 2 == 0);
         tick();
      end
      chk("lat_cen_half", 32'(k), 32'd11);
      cen = 1'b1;
      ack(); tick();

      // we[1] alone does not program a channel
      wr(16'hFFF0, 16'h0301, 2'b10);
      hi_cnt = 0;
      repeat (8) begin tick(); hi_cnt += int'(irq); end
      chk("hi_only", 32'(hi_cnt), 32'd0);

      // control word strobes
      wr(16'hFFFE, 16'h0001, 2'b01);
      chk("pass_on", 32'({pass, fail, stop}), 32'b100);
      tick();
      chk("pass_off", 32'(pass), 32'd0);
      wr(16'hFFFE, 16'h0000, 2'b01);
      chk("fail_on", 32'({pass, fail, stop}), 32'b010);
      wr(16'hFFFE, 16'h0000, 2'b10);
      chk("stop_on", 32'({pass, fail, stop}), 32'b001);
      wr(16'hFFFE, 16'h0001, 2'b11);
      chk("pass_stop", 32'({pass, fail, stop}), 32'b101);
      wr(16'hFFFC, 16'h0001, 2'b11);
      chk("ctrl_miss", 32'({pass, fail, stop}), 32'b000);

      // asynchronous reset mid-count
      wr(16'hFFF0, 16'h0A03, 2'b01);
      wr(16'hFFF2, 16'h0107, 2'b01);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_irq",  32'(irq),   32'd0);
      chk("mid_rst_pend", 32'(pend),  32'd0);
      chk("mid_rst_lvl",  32'(intrq), 32'd0);
      model_reset();
      tick();
      rst_n = 1'b1;
      hi_cnt = 0;
      repeat (15) begin tick(); hi_cnt += int'(irq); end
      chk("post_rst_quiet", 32'(hi_cnt), 32'd0);

`ifdef JT900H_SIMIRQ_RELOAD_EN
      // auto-reload: $0409 -> irq every 5 cen cycles when acked
      wr(16'hFFF0, 16'h0409, 2'b01);
      wait_irq(20, k);
      chk("rl_first", 32'(k), 32'd5);
      for (int p = 0; p < 3; p++) begin
         ack();
         tick();
         wait_irq(20, k);
         chk("rl_period", 32'(k + 2), 32'd5);
      end
      repeat (12) tick();
      chk("rl_single_pend", 32'(pend), 32'h1);
      chk("rl_lvl", 32'(intrq), 32'd1);
      wr(16'hFFF0, 16'h0000, 2'b01);
      tick();
      chk("rl_cancel", 32'(irq), 32'd0);
`endif

      // randomized traffic against the model
      for (int cyc = 0; cyc < 3000; cyc++) begin
         cen     = ($urandom % 4) != 0;
         irq_ack = ($urandom % 3) == 0;
         if ($urandom % 10 == 0) begin
            idx = int'($urandom % 8);
            if ($urandom % 6 == 0)      cval = 0;
            else if ($urandom % 8 == 0) cval = int'($urandom % 256);
            else                        cval = 1 + int'($urandom % 12);
            addr = {8'($urandom), atbl[idx]};
            din  = {8'(cval), 8'($urandom)};
            we   = 2'($urandom_range(1, 3));
         end else begin
            we = '0;
         end
         tick();
      end
      we = '0;
      irq_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
